rs232_tx: RTL and testbench

//   UART transmitter for the UART controller: serialises bytes onto rs232TX
//   as 8N1 frames (1 start, 8 data LSB first, 1 stop), idle-high line.

---
 rtl/rs232_tx_pkg.sv | 16 +
 rtl/rs232_tx_fifo.sv | 61 ++++++
 rtl/rs232_tx.sv | 124 ++++++++++++
 tb/tb_rs232_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rs232_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, 8N1 frame constants and default bit period.
package rs232_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS       = 8;
    localparam logic STOP_LEVEL      = 1'b1;
    localparam logic START_LEVEL     = 1'b0;
    localparam int   DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO between CPU writes and the serialiser; registered full/empty, one-cycle push to visible.
// Push while full is ignored; pop while empty is ignored; empty_nxt gives the post-edge occupancy early.
module rs232_tx_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty,
    output logic         empty_nxt
);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic [W-1:0] mem_q [2**AW];
    logic         do_push, do_pop;

    // Admission uses the registered flags, so a same-cycle pop never frees room for a push.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign pop_dat   = mem_q[rptr_q[AW-1:0]];
    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;

endmodule

// File: rtl/rs232_tx.sv
// 8N1 UART transmitter with internal byte FIFO and private baud divider; line is 0 two edges after a write from idle.
// Frames are 10*CLK_DIV cycles, back-to-back while the FIFO holds data; writes while full are dropped.
module rs232_tx
    import rs232_tx_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       write,
    output logic       full,
    output logic       rs232TX,
    output logic       busy
);

    localparam int CW = $clog2(CLK_DIV);

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic            bit_done;
    logic            fifo_pop;
    logic [7:0]      fifo_dat;
    logic            fifo_full, fifo_empty, fifo_empty_nxt;

    rs232_tx_fifo #(
        .AW(FIFO_AW),
        .W (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (write),
        .push_dat (data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .empty_nxt(fifo_empty_nxt)
    );

    assign bit_done = (baud_q == CW'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_done ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'(1);
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        bit_d    = '0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the registered state, so it trails the FSM by one cycle.
    always_comb begin
        tx_d = STOP_LEVEL;
        case (state_q)
            ST_START: tx_d = START_LEVEL;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = STOP_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE) || !fifo_empty_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign rs232TX = tx_q;
    assign busy    = busy_q;
    assign full    = fifo_full;

endmodule

// File: tb/tb_rs232_tx.sv
// Directed/randomised bench for rs232_tx with CLK_DIV=4: a line-decoding receiver and frame arithmetic give expectations.
module tb_rs232_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       write;
    logic       full;
    logic       rs232TX;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    byte unsigned rx_byte[$];
    int           rx_start[$];

    rs232_tx #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .write  (write),
        .full   (full),
        .rs232TX(rs232TX),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: find the start bit, then sample each bit near its middle.
    initial begin : monitor
        logic [7:0] b;
        int         st;
        forever begin
            @(negedge clk);
            if (rs232TX === 1'b0 && rst === 1'b0) begin
                st = cyc;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = rs232TX;
                end
                repeat (DIV) @(negedge clk);
                rx_byte.push_back(b);
                rx_start.push_back(st);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int limit);
        for (int k = 0; k < limit && rx_byte.size() < n; k++) tick();
        repeat (2 * DIV) tick();
    endtask

    logic [9:0]   fr;
    byte unsigned bq[6];
    int           n0, rc, late, gap_ok;
    int           sent, guard;
    logic         low_seen;

    initial begin
        rst = 1'b1; write = 1'b0; data = 8'h00;
        repeat (3) tick();
        chk("reset_tx", 32'(rs232TX), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 1: single 0xA5 frame, cycle by cycle
        data = 8'hA5; write = 1'b1; tick(); write = 1'b0;
        n0 = cyc;
        chk("t1_busy_after_write", 32'(busy), 32'd1);
        tick();
        chk("t1_line_idle_n1", 32'(rs232TX), 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            tick();
            chk($sformatf("t1_line_c%0d", k), 32'(rs232TX), 32'(fr[k / DIV]));
        end
        chk("t1_busy_last_stop", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_after_frame", 32'(busy), 32'd0);
        chk("t1_line_after_frame", 32'(rs232TX), 32'd1);
        wait_rx(1, 20);
        chk("t1_rx_count", 32'(rx_byte.size()), 32'd1);
        chk("t1_rx_start", 32'(rx_start[0]), 32'(n0 + 2));
        rx_byte.delete(); rx_start.delete();

        // 2: three bytes back to back, no gap
        data = 8'h00; write = 1'b1; tick(); n0 = cyc;
        data = 8'hFF; tick();
        data = 8'h55; tick();
        write = 1'b0;
        wait_rx(3, 5 * FRAME);
        chk("t2_rx_count", 32'(rx_byte.size()), 32'd3);
        if (rx_byte.size() == 3) begin
            chk("t2_b0", 32'(rx_byte[0]), 32'h00);
            chk("t2_b1", 32'(rx_byte[1]), 32'hFF);
            chk("t2_b2", 32'(rx_byte[2]), 32'h55);
            chk("t2_first_start", 32'(rx_start[0]), 32'(n0 + 2));
            gap_ok = ((rx_start[1] - rx_start[0]) == FRAME && (rx_start[2] - rx_start[1]) == FRAME) ? 1 : 0;
            chk("t2_no_gap", 32'(gap_ok), 32'd1);
        end
        chk("t2_busy_end", 32'(busy), 32'd0);
        rx_byte.delete(); rx_start.delete();
        repeat (5) tick();

        // 3: six writes, one popped, four stored, sixth dropped
        for (int i = 0; i < 6; i++) bq[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            data = bq[i]; write = 1'b1; tick();
            if (i == 3) chk("t3_not_full_at_4", 32'(full), 32'd0);
            if (i == 4) chk("t3_full_at_5", 32'(full), 32'd1);
        end
        write = 1'b0;
        chk("t3_full_after_6", 32'(full), 32'd1);
        wait_rx(6, 7 * FRAME);
        chk("t3_rx_count", 32'(rx_byte.size()), 32'd5);
        if (rx_byte.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t3_b%0d", i), 32'(rx_byte[i]), 32'(bq[i]));
        rx_byte.delete(); rx_start.delete();
        repeat (5) tick();

        // 4: write while full on the STOP->START pop edge
        for (int i = 0; i < 6; i++) bq[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            data = bq[i]; write = 1'b1; tick();
            if (i == 0) n0 = cyc;
        end
        write = 1'b0;
        repeat (FRAME - 4) tick();
        chk("t4_full_before_pop", 32'(full), 32'd1);
        data = bq[5]; write = 1'b1; tick(); write = 1'b0;
        chk("t4_pop_edge", 32'(cyc), 32'(n0 + FRAME + 1));
        chk("t4_full_after_pop", 32'(full), 32'd0);
        wait_rx(6, 7 * FRAME);
        chk("t4_rx_count", 32'(rx_byte.size()), 32'd5);
        if (rx_byte.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t4_b%0d", i), 32'(rx_byte[i]), 32'(bq[i]));
        rx_byte.delete(); rx_start.delete();
        repeat (5) tick();

        // 5: reset during data bit 3 of 0x0F with two bytes queued
        data = 8'h0F; write = 1'b1; tick(); n0 = cyc;
        data = 8'($urandom); tick();
        data = 8'($urandom); tick();
        write = 1'b0;
        repeat (17) tick();
        chk("t5_line_bit3", 32'(rs232TX), 32'd1);
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        rc = cyc;
        chk("t5_tx_after_rst", 32'(rs232TX), 32'd1);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        chk("t5_full_after_rst", 32'(full), 32'd0);
        low_seen = 1'b0;
        repeat (3 * FRAME) begin
            tick();
            if (rs232TX !== 1'b1) low_seen = 1'b1;
        end
        chk("t5_line_stays_idle", 32'(low_seen), 32'd0);
        late = 0;
        foreach (rx_start[i]) if (rx_start[i] > rc) late++;
        chk("t5_no_new_frames", 32'(late), 32'd0);
        chk("t5_busy_end", 32'(busy), 32'd0);
        rx_byte.delete(); rx_start.delete();
        repeat (5) tick();

        // 6: loopback of every byte value, writing whenever not full
        sent = 0; guard = 0;
        while (sent < 256 && guard < 20000) begin
            if (!full) begin
                data = 8'(sent); write = 1'b1; tick(); write = 1'b0;
                sent++;
            end else begin
                tick();
            end
            guard++;
        end
        chk("t6_all_written", 32'(sent), 32'd256);
        wait_rx(256, 260 * FRAME);
        chk("t6_rx_count", 32'(rx_byte.size()), 32'd256);
        for (int i = 0; i < 256 && i < rx_byte.size(); i++)
            chk($sformatf("t6_b%0d", i), 32'(rx_byte[i]), 32'(i));
        chk("t6_busy_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
